// File: rtl/pipeline_controller.sv
// Control and hazard unit for a 5-stage MIPS-style pipeline: D-stage decode,
// E/M/W control registers, load-use stall, branch/jump flush and E-stage forwarding.
module pipeline_controller #(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    Opcode,
    input  logic [5:0]    Funct,
    input  logic [RW-1:0] RsD,
    input  logic [RW-1:0] RtD,
    input  logic [RW-1:0] RsE,
    input  logic [RW-1:0] RtE,
    input  logic [RW-1:0] WriteRegE,
    input  logic [RW-1:0] WriteRegM,
    input  logic [RW-1:0] WriteRegW,
    input  logic          ZeroM,
    output logic          RegDstE,
    output logic          ALUSrcE,
    output logic [2:0]    ALUControlE,
    output logic          MemWriteM,
    output logic          PCSrcM,
    output logic          JumpD,
    output logic          MemToRegW,
    output logic          RegWriteW,
    output logic          StallF,
    output logic          StallD,
    output logic          FlushD,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

    // Anything not recognised collapses to the all-zero word, which behaves as a NOP.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (fn)
                    FN_ADD:  c.alu_control = ALU_ADD;
                    FN_SUB:  c.alu_control = ALU_SUB;
                    FN_AND:  c.alu_control = ALU_AND;
                    FN_OR:   c.alu_control = ALU_OR;
                    FN_SLT:  c.alu_control = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.mem_to_reg  = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // The M-stage result is younger than W, so it is checked first; $0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                           input logic          wr_m,
                                           input logic [RW-1:0] dst_m,
                                           input logic          wr_w,
                                           input logic [RW-1:0] dst_w);
        logic [1:0] sel;
        sel = FWD_RD;
        if (wr_m && (dst_m != '0) && (dst_m == src))
            sel = FWD_MEM;
        else if (wr_w && (dst_w != '0) && (dst_w == src))
            sel = FWD_WB;
        return sel;
    endfunction

    ctrl_t ctrl_d;
    logic  jump_dec;
    logic  lw_stall;
    logic  pc_src;

    ctrl_t ctrl_p0;
    logic  reg_write_p1;
    logic  mem_to_reg_p1;
    logic  mem_write_p1;
    logic  branch_p1;
    logic  reg_write_p2;
    logic  mem_to_reg_p2;

    // D stage: decode and hazard detection
    always_comb begin
        ctrl_d   = decode(Opcode, Funct);
        jump_dec = (Opcode == OP_J);
        pc_src   = branch_p1 & ZeroM;
        lw_stall = ctrl_p0.mem_to_reg & ctrl_p0.reg_write &
                   ((WriteRegE == RsD) | (WriteRegE == RtD));
    end

    assign StallF = lw_stall & ~pc_src;
    assign StallD = lw_stall & ~pc_src;
    assign JumpD  = jump_dec & ~pc_src & ~lw_stall;
    assign FlushD = pc_src | JumpD;

    // D->E register: a stall injects a bubble, a taken branch squashes the slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl_p0 <= '0;
        else if (pc_src || lw_stall)
            ctrl_p0 <= '0;
        else
            ctrl_p0 <= ctrl_d;
    end

    // E->M register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_write_p1  <= 1'b0;
            branch_p1     <= 1'b0;
        end else if (pc_src) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_write_p1  <= 1'b0;
            branch_p1     <= 1'b0;
        end else begin
            reg_write_p1  <= ctrl_p0.reg_write;
            mem_to_reg_p1 <= ctrl_p0.mem_to_reg;
            mem_write_p1  <= ctrl_p0.mem_write;
            branch_p1     <= ctrl_p0.branch;
        end
    end

    // M->W register: the resolving branch itself always completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
        end else begin
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
        end
    end

    assign RegDstE     = ctrl_p0.reg_dst;
    assign ALUSrcE     = ctrl_p0.alu_src;
    assign ALUControlE = ctrl_p0.alu_control;
    assign MemWriteM   = mem_write_p1;
    assign PCSrcM      = pc_src;
    assign MemToRegW   = mem_to_reg_p2;
    assign RegWriteW   = reg_write_p2;

    assign ForwardAE = fwd_sel(RsE, reg_write_p1, WriteRegM, reg_write_p2, WriteRegW);
    assign ForwardBE = fwd_sel(RtE, reg_write_p1, WriteRegM, reg_write_p2, WriteRegW);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a cycle-by-cycle vector table with hand-derived
// control words, plus a hand-written asynchronous mid-stream reset sequence.
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       ZeroM;
    logic       RegDstE, ALUSrcE, MemWriteM, PCSrcM, JumpD, MemToRegW, RegWriteW;
    logic       StallF, StallD, FlushD;
    logic [2:0] ALUControlE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [16:0] got;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_controller #(.RW(5)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .ZeroM(ZeroM),
        .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .JumpD(JumpD),
        .MemToRegW(MemToRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    assign got = {RegDstE, ALUSrcE, ALUControlE, MemWriteM, PCSrcM, JumpD,
                  MemToRegW, RegWriteW, StallF, StallD, FlushD, ForwardAE, ForwardBE};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, FNOP = 6'b000000, FBAD = 6'b111111;
    localparam logic [16:0] Z = 17'd0;

    typedef struct {
        logic [95:0] name;
        logic [5:0]  op, fn;
        logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
        logic        zm;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] ex(input logic rd, input logic as, input logic [2:0] ac,
                                       input logic mw, input logic pc, input logic jd,
                                       input logic mr, input logic rw, input logic st,
                                       input logic fl, input logic [1:0] fa, input logic [1:0] fb);
        return {rd, as, ac, mw, pc, jd, mr, rw, st, st, fl, fa, fb};
    endfunction

    task automatic v(input logic [95:0] nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rsd, input logic [4:0] rtd,
                     input logic [4:0] rse, input logic [4:0] rte, input logic [4:0] wre,
                     input logic [4:0] wrm, input logic [4:0] wrw, input logic zm,
                     input logic [16:0] e);
        vec_t t;
        t.name = nm; t.op = op; t.fn = fn; t.rsd = rsd; t.rtd = rtd;
        t.rse = rse; t.rte = rte; t.wre = wre; t.wrm = wrm; t.wrw = wrw;
        t.zm = zm; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        Opcode = t.op; Funct = t.fn; RsD = t.rsd; RtD = t.rtd;
        RsE = t.rse; RtE = t.rte; WriteRegE = t.wre;
        WriteRegM = t.wrm; WriteRegW = t.wrw; ZeroM = t.zm;
    endtask

    task automatic drive_d(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rsd, input logic [4:0] rtd);
        Opcode = op; Funct = fn; RsD = rsd; RtD = rtd;
        RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        ZeroM = 1'b0;
    endtask

    task automatic check(input logic [95:0] nm, input logic [16:0] act, input logic [16:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %0s got=%05h want=%05h", nm, act, e);
        end
    endtask

    initial begin
        // E stage: add $3,$1,$2 -> sub $4,$3,$1 back to back, then with one NOP between
        v("fwd_d_add", R, FADD, 1, 2, 0, 0, 0, 0, 0, 0, Z);
        v("fwd_e_add", R, FSUB, 3, 1, 1, 2, 3, 0, 0, 0, ex(1,0,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("fwd_m",     R, FNOP, 0, 0, 3, 1, 4, 3, 0, 0, ex(1,0,3'b110,0,0,0,0,0,0,0,2'b10,2'b00));
        v("wb_add",    R, FNOP, 0, 0, 0, 0, 0, 4, 3, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        v("wb_sub",    R, FADD, 1, 2, 0, 0, 0, 0, 4, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        v("e_add2",    R, FNOP, 0, 0, 1, 2, 3, 0, 0, 0, ex(1,0,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("d_sub2",    R, FSUB, 3, 1, 0, 0, 0, 3, 0, 0, Z);
        v("fwd_w",     R, FNOP, 0, 0, 3, 1, 4, 0, 3, 0, ex(1,0,3'b110,0,0,0,0,1,0,0,2'b01,2'b00));
        // $0 as a destination is never forwarded
        v("d_addi0",   ADDI, FNOP, 1, 0, 0, 0, 0, 4, 0, 0, Z);
        v("e_addi0",   R, FADD, 0, 0, 1, 0, 0, 0, 4, 0, ex(0,1,3'b010,0,0,0,0,1,0,0,2'b00,2'b00));
        v("no_fwd_r0", R, FNOP, 0, 0, 0, 0, 5, 0, 0, 0, ex(1,0,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("no_fwd_w0", R, FNOP, 0, 0, 0, 0, 0, 5, 0, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        v("wb_add5",   R, FNOP, 0, 0, 0, 0, 0, 0, 5, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        v("idle",      R, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        // lw $2,0($0) -> add $3,$2,$2
        v("d_lw",      LW, FNOP, 0, 2, 0, 0, 0, 0, 0, 0, Z);
        v("lwstall",   R, FADD, 2, 2, 0, 2, 2, 0, 0, 0, ex(0,1,3'b010,0,0,0,0,0,1,0,2'b00,2'b00));
        v("bubble",    R, FADD, 2, 2, 0, 0, 0, 2, 0, 0, Z);
        v("lw_fwd_w",  R, FNOP, 0, 0, 2, 2, 3, 0, 2, 0, ex(1,0,3'b010,0,0,0,1,1,0,0,2'b01,2'b01));
        v("wb_bubble", R, FNOP, 0, 0, 0, 0, 0, 3, 0, 0, Z);
        v("wb_add3",   R, FNOP, 0, 0, 0, 0, 0, 0, 3, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        // taken beq $1,$1 followed by addi, sw, (fetched) -- all squashed
        v("d_beq",     BEQ, FNOP, 1, 1, 0, 0, 0, 0, 0, 0, Z);
        v("e_beq",     ADDI, FNOP, 1, 5, 1, 1, 1, 0, 0, 0, ex(0,0,3'b110,0,0,0,0,0,0,0,2'b00,2'b00));
        v("beq_taken", SW, FNOP, 0, 5, 1, 5, 5, 1, 0, 1, ex(0,1,3'b010,0,1,0,0,0,0,1,2'b00,2'b00));
        v("beq_w",     R, FNOP, 0, 0, 0, 0, 0, 0, 1, 0, Z);
        v("squash_m",  R, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        v("squash_w",  R, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        // not-taken beq: the younger addi survives to W
        v("d_beq_nt",  BEQ, FNOP, 1, 2, 0, 0, 0, 0, 0, 0, Z);
        v("e_beq_nt",  ADDI, FNOP, 1, 6, 1, 2, 2, 0, 0, 0, ex(0,0,3'b110,0,0,0,0,0,0,0,2'b00,2'b00));
        v("beq_not",   R, FNOP, 0, 0, 1, 6, 6, 2, 0, 0, ex(0,1,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("nt_m",      R, FNOP, 0, 0, 0, 0, 0, 6, 2, 0, Z);
        v("nt_wb",     R, FNOP, 0, 0, 0, 0, 0, 0, 6, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        // taken beq in M while lw in E and its consumer in D
        v("d_beq5",    BEQ, FNOP, 1, 1, 0, 0, 0, 0, 0, 0, Z);
        v("e_beq5",    LW, FNOP, 0, 2, 1, 1, 1, 0, 0, 0, ex(0,0,3'b110,0,0,0,0,0,0,0,2'b00,2'b00));
        v("flush_wins", R, FADD, 2, 2, 0, 2, 2, 1, 0, 1, ex(0,1,3'b010,0,1,0,0,0,0,1,2'b00,2'b00));
        v("target_d",  R, FNOP, 0, 0, 0, 0, 0, 0, 1, 0, Z);
        v("lw_squash", R, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        // jumps: plain, against a load-use stall, against a taken branch
        v("jump",      J, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,3'b000,0,0,1,0,0,0,1,2'b00,2'b00));
        v("after_j",   R, FNOP, 0, 0, 0, 0, 0, 0, 0, 0, Z);
        v("d_lw_j",    LW, FNOP, 0, 2, 0, 0, 0, 0, 0, 0, Z);
        v("j_vs_stall", J, FNOP, 2, 0, 0, 2, 2, 0, 0, 0, ex(0,1,3'b010,0,0,0,0,0,1,0,2'b00,2'b00));
        v("j_released", J, FNOP, 2, 0, 0, 0, 0, 2, 0, 0, ex(0,0,3'b000,0,0,1,0,0,0,1,2'b00,2'b00));
        v("lw_wb_j",   R, FNOP, 0, 0, 0, 0, 0, 0, 2, 0, ex(0,0,3'b000,0,0,0,1,1,0,0,2'b00,2'b00));
        v("d_beq_j",   BEQ, FNOP, 1, 1, 0, 0, 0, 0, 0, 0, Z);
        v("e_beq_j",   R, FNOP, 0, 0, 1, 1, 1, 0, 0, 0, ex(0,0,3'b110,0,0,0,0,0,0,0,2'b00,2'b00));
        v("j_vs_br",   J, FNOP, 0, 0, 0, 0, 0, 1, 0, 1, ex(0,0,3'b000,0,1,0,0,0,0,1,2'b00,2'b00));
        v("beq_w_j",   R, FNOP, 0, 0, 0, 0, 0, 0, 1, 0, Z);
        // illegal opcode travels as an all-zero word
        v("bad_d",     BAD, FADD, 1, 2, 0, 0, 0, 0, 0, 0, Z);
        v("bad_e",     R, FNOP, 0, 0, 1, 2, 2, 0, 0, 0, Z);
        v("bad_m",     R, FNOP, 0, 0, 0, 0, 0, 2, 0, 0, Z);
        v("bad_w",     R, FNOP, 0, 0, 0, 0, 0, 0, 2, 0, Z);
        // remaining ALU functions and an unknown funct
        v("d_and",     R, FAND, 1, 2, 0, 0, 0, 0, 0, 0, Z);
        v("e_and",     R, FOR,  1, 2, 1, 2, 3, 0, 0, 0, ex(1,0,3'b000,0,0,0,0,0,0,0,2'b00,2'b00));
        v("e_or",      R, FSLT, 1, 2, 1, 2, 4, 3, 0, 0, ex(1,0,3'b001,0,0,0,0,0,0,0,2'b00,2'b00));
        v("e_slt",     R, FBAD, 1, 2, 1, 2, 5, 4, 3, 0, ex(1,0,3'b111,0,0,0,0,1,0,0,2'b00,2'b00));
        v("bad_funct", R, FNOP, 0, 0, 1, 2, 6, 5, 4, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        v("wb_slt",    R, FNOP, 0, 0, 0, 0, 0, 6, 5, 0, ex(0,0,3'b000,0,0,0,0,1,0,0,2'b00,2'b00));
        // sw carries MemWrite to M and writes nothing in W
        v("d_sw",      SW, FNOP, 0, 5, 0, 0, 0, 0, 6, 0, Z);
        v("sw_e",      R, FNOP, 0, 0, 0, 5, 5, 0, 0, 0, ex(0,1,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("sw_m",      R, FNOP, 0, 0, 0, 0, 0, 5, 0, 0, ex(0,0,3'b000,1,0,0,0,0,0,0,2'b00,2'b00));
        v("sw_w",      R, FNOP, 0, 0, 0, 0, 0, 0, 5, 0, Z);
        // two writers of $3 in M and W: M wins on the B operand
        v("d_add_a",   R, FADD, 1, 2, 0, 0, 0, 0, 0, 0, Z);
        v("d_add_b",   R, FADD, 1, 2, 1, 2, 3, 0, 0, 0, ex(1,0,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("d_sub_mw",  R, FSUB, 4, 3, 1, 2, 3, 3, 0, 0, ex(1,0,3'b010,0,0,0,0,0,0,0,2'b00,2'b00));
        v("m_beats_w", R, FNOP, 0, 0, 4, 3, 5, 3, 3, 0, ex(1,0,3'b110,0,0,0,0,1,0,0,2'b00,2'b10));

        reset = 1'b1;
        drive_d(R, FNOP, 0, 0);
        @(negedge clk);
        #1 check("reset_state", got, Z);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1 check(vecs[i].name, got, vecs[i].exp);
            @(negedge clk);
        end

        // addi then sw: with sw in M and addi in W, pull reset between edges
        drive_d(ADDI, FNOP, 1, 7);
        @(negedge clk);
        drive_d(SW, FNOP, 0, 7);
        @(negedge clk);
        drive_d(R, FNOP, 0, 0);
        @(negedge clk);
        #1 check("pre_reset", {15'd0, MemWriteM, RegWriteW}, 17'd3);
        reset = 1'b1;
        #1 check("async_reset", {15'd0, MemWriteM, RegWriteW}, 17'd0);
        check("async_all", got, Z);
        @(negedge clk);
        #1 check("reset_hold", got, Z);
        reset = 1'b0;
        @(negedge clk);
        #1 check("post_reset", got, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
